// File: rtl/circle_seg_pkg.sv
// Shared constants and path helpers for the circle animation.
// Maps path positions onto digit index and upper/lower row.
package circle_seg_pkg;

   localparam logic [7:0] SEG_UPPER = 8'b0_1100011;
   localparam logic [7:0] SEG_LOWER = 8'b0_1011100;
   localparam logic [7:0] SEG_OFF   = 8'b0_0000000;

   function automatic int pos_width(input int n);
      return $clog2(2 * n);
   endfunction

   function automatic int pos_to_digit(input int pos, input int n);
      return (pos < n) ? pos : (2 * n - 1 - pos);
   endfunction

   function automatic logic pos_to_row(input int pos, input int n);
      return (pos < n);
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter with enable and synchronous clear.
// Emits a one-cycle tick on the terminal count.
module tick_divider #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [W-1:0] r_cnt;
   logic         w_term;

   assign w_term = (r_cnt == W'(DIV - 1));
   assign tick   = en & ~clr & w_term;

   // count while enabled, clear has priority over the wrap to zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= w_term ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/circle_path_ctrl.sv
// Moves a circle along the upper then lower digit rows while
// time-multiplexing the digit anodes.
module circle_path_ctrl
   import circle_seg_pkg::*;
#(
   parameter int N_DIGITS = 4,
   parameter int SCAN_DIV = 50_000,
   parameter int STEP_DIV = 25_000_000,
   parameter int AN_LOGIC = 0
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                run,
   input  logic                                dir,
   input  logic                                clear,
   output logic [N_DIGITS-1:0]                 an,
   output logic                                row,
   output logic                                enable,
   output logic [$clog2(2*N_DIGITS)-1:0]       pos,
   output logic                                wrap
);

   localparam int PW = pos_width(N_DIGITS);
   localparam int SW = $clog2(N_DIGITS);
   localparam logic [PW-1:0] PLAST = PW'(2 * N_DIGITS - 1);
   localparam logic [SW-1:0] SLAST = SW'(N_DIGITS - 1);

   logic                w_scan_tick;
   logic                w_step_tick;
   logic [SW-1:0]       r_scan_idx;
   logic [PW-1:0]       r_pos;
   logic                r_wrap;
   logic [N_DIGITS-1:0] r_an_hot;
   logic                r_row;
   logic                r_enable;
   logic [PW-1:0]       w_pos_nxt;
   logic                w_wrap_nxt;

   tick_divider #(.DIV(SCAN_DIV)) u_scan (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (1'b1),
      .clr   (1'b0),
      .tick  (w_scan_tick)
   );

   tick_divider #(.DIV(STEP_DIV)) u_step (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (run),
      .clr   (clear),
      .tick  (w_step_tick)
   );

   // advance the scanned digit on every scan tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan_idx <= '0;
      end else if (w_scan_tick) begin
         r_scan_idx <= (r_scan_idx == SLAST) ? '0 : r_scan_idx + 1'b1;
      end
   end

   // next position around the closed path and whether it wraps
   always_comb begin
      w_pos_nxt  = r_pos;
      w_wrap_nxt = 1'b0;
      if (dir) begin
         w_pos_nxt  = (r_pos == '0) ? PLAST : r_pos - 1'b1;
         w_wrap_nxt = (r_pos == '0);
      end else begin
         w_pos_nxt  = (r_pos == PLAST) ? '0 : r_pos + 1'b1;
         w_wrap_nxt = (r_pos == PLAST);
      end
   end

   // position update; clear wins over a coincident step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pos  <= '0;
         r_wrap <= 1'b0;
      end else if (clear) begin
         r_pos  <= '0;
         r_wrap <= 1'b0;
      end else if (w_step_tick) begin
         r_pos  <= w_pos_nxt;
         r_wrap <= w_wrap_nxt;
      end else begin
         r_wrap <= 1'b0;
      end
   end

   // register digit drive from current scan slot and position
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_an_hot <= '0;
         r_row    <= 1'b0;
         r_enable <= 1'b0;
      end else begin
         r_an_hot <= N_DIGITS'(1) << r_scan_idx;
         r_row    <= pos_to_row(int'(r_pos), N_DIGITS);
         r_enable <= (int'(r_scan_idx) ==
                      pos_to_digit(int'(r_pos), N_DIGITS));
      end
   end

   assign an     = (AN_LOGIC != 0) ? ~r_an_hot : r_an_hot;
   assign row    = r_row;
   assign enable = r_enable;
   assign pos    = r_pos;
   assign wrap   = r_wrap;

endmodule

// File: doc/circle_path_ctrl.md
# circle_path_ctrl

Sequential controller that animates a single "circle" (upper or lower half-square) around a row of multiplexed 7-segment digits. The circle travels along the upper row, then back along the lower row. The block time-multiplexes the digits: it drives a one-hot anode select plus the `row`/`enable` pair consumed by the team's single-digit circle segment encoder, which sits directly downstream and converts the pair into segment patterns.

## Interface
- `N_DIGITS`, 4, number of multiplexed digits; must be ≥ 2.
- `SCAN_DIV`, 50_000, clock cycles per digit scan slot; must be ≥ 1.
- `STEP_DIV`, 25_000_000, clock cycles per animation step while running; must be ≥ 1.
- `AN_LOGIC`, 0, anode polarity: 0 = active-high, 1 = all `an` bits inverted.
- `clk`  in  1  single system clock; all state is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  1 = animation advances; 0 = position frozen (scanning continues).
- `dir`  in  1  0 = forward (pos +1), 1 = reverse (pos −1).
- `clear`  in  1  synchronous; forces pos and step counter to 0.
- `an`  out  N_DIGITS  one-hot digit select (polarity per AN_LOGIC).
- `row`  out  1  1 = upper circle, 0 = lower circle, for the currently selected digit.
- `enable`  out  1  1 = the circle is lit on the currently selected digit.
- `pos`  out  $clog2(2*N_DIGITS)  current path position.
- `wrap`  out  1  one-cycle pulse when pos wraps around.

## Operation
- **Path.** P = 2*N_DIGITS positions. Digit 0 is the leftmost digit.
  - pos 0..N−1: digit = pos, row = 1.
  - pos N..P−1: digit = P−1−pos, row = 0.
- **Scan.** scan_cnt counts 0..SCAN_DIV−1 continuously, independent of run and clear.
  - At terminal count, scan_idx advances; N−1 wraps to 0.
- **Step.** step_cnt counts 0..STEP_DIV−1 only while run = 1; it holds while run = 0.
  - At terminal count, step_cnt returns to 0 and pos moves: dir = 0 gives (pos+1) mod P, dir = 1 gives (pos−1) mod P.
- **Wrap.** wrap = 1 for the single cycle after pos moves P−1→0 (forward) or 0→P−1 (reverse).
- **Clear.** clear = 1 sets pos = 0 and step_cnt = 0, and overrides any step event in the same cycle. It never causes a wrap pulse.
- **Direction change.** A change of dir takes effect at the next step event; step_cnt is not reset.
- **Outputs.**
  - an = one-hot(scan_idx), XOR-inverted when AN_LOGIC = 1.
  - enable = (scan_idx == digit(pos)).
  - row = row(pos).

## Timing
- **Reset values** (asynchronous, while rst_n = 0): scan_cnt = 0, scan_idx = 0, step_cnt = 0, pos = 0, row = 0, enable = 0, wrap = 0.
  - an = all zeros when AN_LOGIC = 0; all ones when AN_LOGIC = 1.
  - Reset asserted mid-operation forces these values immediately, regardless of clock.
- **Output registration.** an, row and enable are registered from the current scan_idx and pos: 1-cycle latency after either register changes.
  - First clock edge after reset release: an selects digit 0, row = 1, enable = 1.
- **pos and wrap.** Both update on the clock edge of the step event; pos is itself a register, so it carries no extra latency.
- **Step interval.** With run held at 1, pos changes every STEP_DIV cycles exactly. STEP_DIV = 1 advances pos every cycle.
- **Pausing.** Deasserting run for k cycles delays the next step by k cycles; the partial count is retained.
- **Simultaneous events.** A scan event and a step event in the same cycle are both applied. The registered outputs then reflect the new scan_idx and the new pos together, with no mixed-state cycle.

## Structure
- Package `circle_seg_pkg`:
  - Circle segment constants (upper = 8'b0_1100011, lower = 8'b0_1011100, off = 0).
  - Functions `pos_to_digit` and `pos_to_row`, parameterised by N_DIGITS.
  - Position width helper.
- Sub-module `tick_divider`: parameter DIV, inputs clk, rst_n, en, clr, output one-cycle `tick` at terminal count. It is instantiated twice:
  - scan: en = 1, clr = 0.
  - step: en = run, clr = clear.
- The top level holds scan_idx, pos, wrap and the output registers.

## Test plan
All scenarios use N_DIGITS = 4, SCAN_DIV = 2, STEP_DIV = 3, AN_LOGIC = 0 unless stated.

1. **Reset.** Assert rst_n = 0 mid-animation → an = 0000, row = 0, enable = 0, pos = 0, wrap = 0 immediately. Release → next edge gives an = 0001, row = 1, enable = 1.
2. **Scan only.** run = 0 → an sequence 0001, 0010, 0100, 1000, each held 2 cycles, repeating. enable = 1 only while an = 0001; pos stays 0.
3. **Forward run.** run = 1, dir = 0 → pos 0,1,…,7 with 3 cycles each.
   - At pos = 5, enable is high only when an = 0100, with row = 0.
   - wrap pulses for 1 cycle on the 7→0 transition.
4. **Reverse and pause.** From pos = 0: dir = 1, run = 1 → pos = 7 after 3 cycles with a wrap pulse. Drop run for 5 cycles after 1 counted cycle → the next step occurs 2 counted cycles after run returns.
5. **Clear priority.** Assert clear in the same cycle as a step terminal count at pos = 7 → pos = 0, wrap = 0, and the next step occurs 3 cycles later.
6. **Inverted anodes.** AN_LOGIC = 1 → an = 1111 in reset; scan sequence 1110, 1101, 1011, 0111; row and enable unaffected.
